// File: rtl/enemy_formation_if.sv
// Bus between the enemy formation controller, the frame tick source, the
// player-shot collision logic and the pixel renderer.
interface enemy_formation_if #(
   parameter int ROWS_P = 4,
   parameter int COLS_P = 8
);
   localparam int N_SLOTS = ROWS_P * COLS_P;
   localparam int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int CNT_W   = $clog2(N_SLOTS + 1);

   logic               start_i;
   logic               frame_i;
   logic               hit_i;
   logic [IDX_W-1:0]   hit_idx_i;
   logic [9:0]         left_o;
   logic [9:0]         top_o;
   logic [N_SLOTS-1:0] alive_o;
   logic [CNT_W-1:0]   alive_count_o;
   logic               step_o;
   logic               landed_o;
   logic               cleared_o;

   modport master (
      output start_i, frame_i, hit_i, hit_idx_i,
      input  left_o, top_o, alive_o, alive_count_o, step_o, landed_o, cleared_o
   );

   modport slave (
      input  start_i, frame_i, hit_i, hit_idx_i,
      output left_o, top_o, alive_o, alive_count_o, step_o, landed_o, cleared_o
   );
endinterface

// File: rtl/enemy_formation.sv
// Formation controller: per-slot alive bits, shared origin, march/bounce/descend FSM.
// Define ENEMY_FORMATION_SPEEDUP_EN to make the step delay shrink with the live count.
//
// state       | meaning
// IDLE        | waiting for start, hits and frames ignored
// MARCH_RIGHT | stepping right on each tick, descend at the right bound
// MARCH_LEFT  | stepping left on each tick, descend at the left bound
// LANDED      | formation reached the landing line, frozen until start
// CLEARED     | every enemy dead, frozen until start
module enemy_formation #(
   parameter int ROWS_P       = 4,
   parameter int COLS_P       = 8,
   parameter int ENEMY_W_P    = 40,
   parameter int ENEMY_H_P    = 10,
   parameter int GAP_X_P      = 8,
   parameter int GAP_Y_P      = 8,
   parameter int STEP_X_P     = 10,
   parameter int STEP_Y_P     = 10,
   parameter int SCREEN_W_P   = 640,
   parameter int LAND_Y_P     = 440,
   parameter int START_LEFT_P = 9,
   parameter int START_TOP_P  = 9,
   parameter int BASE_DELAY_P = 30,
   parameter int MIN_DELAY_P  = 2
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   enemy_formation_if.slave bus
);

   localparam int N_SLOTS   = ROWS_P * COLS_P;
   localparam int IDX_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int CNT_W     = $clog2(N_SLOTS + 1);
   localparam int COL_W     = (COLS_P > 1) ? $clog2(COLS_P) : 1;
   localparam int ROW_W     = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
   localparam int DELAY_MAX = (BASE_DELAY_P > MIN_DELAY_P + N_SLOTS) ?
                              BASE_DELAY_P : MIN_DELAY_P + N_SLOTS;
   localparam int FC_W      = $clog2(DELAY_MAX + 1);

   localparam logic [10:0] PITCH_X  = 11'(ENEMY_W_P + GAP_X_P);
   localparam logic [10:0] PITCH_Y  = 11'(ENEMY_H_P + GAP_Y_P);
   localparam logic [10:0] W11      = 11'(ENEMY_W_P);
   localparam logic [10:0] H11      = 11'(ENEMY_H_P);
   localparam logic [10:0] STEP_X11 = 11'(STEP_X_P);
   localparam logic [10:0] SCREEN11 = 11'(SCREEN_W_P);
   localparam logic [10:0] LAND11   = 11'(LAND_Y_P);
   localparam logic [9:0]  STEP_X10 = 10'(STEP_X_P);
   localparam logic [9:0]  STEP_Y10 = 10'(STEP_Y_P);
   localparam logic [9:0]  LEFT0    = 10'(START_LEFT_P);
   localparam logic [9:0]  TOP0     = 10'(START_TOP_P);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SLOTS);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [FC_W-1:0]  ONE_FC   = FC_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      MARCH_RIGHT,
      MARCH_LEFT,
      LANDED,
      CLEARED
   } state_t;

   state_t             state_q;
   logic [9:0]         left_q;
   logic [9:0]         top_q;
   logic [N_SLOTS-1:0] alive_q;
   logic [CNT_W-1:0]   count_q;
   logic [FC_W-1:0]    frame_cnt_q;
   logic               step_q;
   logic               landed_q;
   logic               cleared_q;

   logic [COLS_P-1:0]  col_live;
   logic [ROWS_P-1:0]  row_live;
   logic [COL_W-1:0]   lcol;
   logic [COL_W-1:0]   rcol;
   logic [ROW_W-1:0]   brow;

   always_comb begin
      col_live = '0;
      row_live = '0;
      for (int r = 0; r < ROWS_P; r++) begin
         for (int c = 0; c < COLS_P; c++) begin
            if (alive_q[r*COLS_P + c]) begin
               col_live[c] = 1'b1;
               row_live[r] = 1'b1;
            end
         end
      end
      lcol = '0;
      rcol = '0;
      brow = '0;
      for (int c = COLS_P - 1; c >= 0; c--) begin
         if (col_live[c]) lcol = COL_W'(c);
      end
      for (int c = 0; c < COLS_P; c++) begin
         if (col_live[c]) rcol = COL_W'(c);
      end
      for (int r = 0; r < ROWS_P; r++) begin
         if (row_live[r]) brow = ROW_W'(r);
      end
   end

   logic [10:0] right_edge;
   logic [10:0] left_edge;
   logic [10:0] bottom;

   assign right_edge = {1'b0, left_q} + 11'(rcol) * PITCH_X + W11;
   assign left_edge  = {1'b0, left_q} + 11'(lcol) * PITCH_X;
   assign bottom     = {1'b0, top_q} + 11'(brow) * PITCH_Y + H11;

   logic [FC_W-1:0] delay;
`ifdef ENEMY_FORMATION_SPEEDUP_EN
   assign delay = FC_W'(MIN_DELAY_P) + FC_W'(count_q);
`else
   assign delay = FC_W'(BASE_DELAY_P);
`endif

   // >= rather than ==: with speed-up a kill can pull the delay below the running count.
   logic tick;
   assign tick = bus.frame_i && ((frame_cnt_q + ONE_FC) >= delay);

   logic idx_in_range;
   if (N_SLOTS == (1 << IDX_W)) begin : g_idx_full
      assign idx_in_range = 1'b1;
   end else begin : g_idx_part
      assign idx_in_range = (int'(bus.hit_idx_i) < N_SLOTS);
   end

   logic hit_ok;
   logic last_hit;
   logic land_now;
   logic fits_right;
   logic fits_left;

   assign hit_ok     = bus.hit_i && idx_in_range && alive_q[bus.hit_idx_i];
   assign last_hit   = hit_ok && (count_q == ONE_CNT);
   assign land_now   = (bottom >= LAND11);
   assign fits_right = ((right_edge + STEP_X11) <= SCREEN11);
   assign fits_left  = (left_edge >= STEP_X11);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         left_q      <= LEFT0;
         top_q       <= TOP0;
         alive_q     <= '1;
         count_q     <= FULL_CNT;
         frame_cnt_q <= '0;
         step_q      <= 1'b0;
         landed_q    <= 1'b0;
         cleared_q   <= 1'b0;
      end else begin
         step_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  state_q     <= MARCH_RIGHT;
                  frame_cnt_q <= '0;
               end
            end
            MARCH_RIGHT, MARCH_LEFT: begin
               if (hit_ok) begin
                  alive_q[bus.hit_idx_i] <= 1'b0;
                  count_q                <= count_q - ONE_CNT;
               end
               // Extents come from pre-hit alive_q, so a same-cycle kill never shifts this tick.
               if (bus.frame_i && !land_now) begin
                  if (tick) begin
                     frame_cnt_q <= '0;
                     step_q      <= 1'b1;
                     if (state_q == MARCH_RIGHT) begin
                        if (fits_right) begin
                           left_q <= left_q + STEP_X10;
                        end else begin
                           top_q   <= top_q + STEP_Y10;
                           state_q <= MARCH_LEFT;
                        end
                     end else begin
                        if (fits_left) begin
                           left_q <= left_q - STEP_X10;
                        end else begin
                           top_q   <= top_q + STEP_Y10;
                           state_q <= MARCH_RIGHT;
                        end
                     end
                  end else begin
                     frame_cnt_q <= frame_cnt_q + ONE_FC;
                  end
               end
               if (last_hit) begin
                  state_q   <= CLEARED;
                  cleared_q <= 1'b1;
               end else if (land_now) begin
                  state_q  <= LANDED;
                  landed_q <= 1'b1;
               end
            end
            LANDED, CLEARED: begin
               if (bus.start_i) begin
                  state_q     <= MARCH_RIGHT;
                  left_q      <= LEFT0;
                  top_q       <= TOP0;
                  alive_q     <= '1;
                  count_q     <= FULL_CNT;
                  frame_cnt_q <= '0;
                  landed_q    <= 1'b0;
                  cleared_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.left_o        = left_q;
   assign bus.top_o         = top_q;
   assign bus.alive_o       = alive_q;
   assign bus.alive_count_o = count_q;
   assign bus.step_o        = step_q;
   assign bus.landed_o      = landed_q;
   assign bus.cleared_o     = cleared_q;

endmodule
